wb_burst_reader: RTL

WB_BURST_READER -- requirements
Module: wb_burst_reader

---
 rtl/wb_burst_reader_if.sv | 25 ++
 rtl/wb_burst_reader.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/wb_burst_reader_if.sv
// Wishbone B4 pipelined-less bus bundle shared by master and slave.
// Signals: cyc stb we sel adr cti bte (master) ack err rty dat_sm (slave).
interface wshb_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack;
  logic        err;
  logic        rty;
  logic [31:0] dat_sm;

  modport master (
    output cyc, stb, we, sel, adr, cti, bte,
    input  ack, err, rty, dat_sm
  );

  modport slave (
    input  cyc, stb, we, sel, adr, cti, bte,
    output ack, err, rty, dat_sm
  );
endinterface

// File: rtl/wb_burst_reader.sv
// Wishbone burst reader: streams NWORDS words from BASE_ADR into a FWFT FIFO.
// Ports: clk, rst (async high), start, continuous, busy, done, error,
//   wb_m (Wishbone master), rd_en, rd_data, empty, level (FIFO side).
module wb_burst_reader #(
  parameter logic [31:0] BASE_ADR   = 32'h0000_0000,
  parameter int          NWORDS     = 2048,
  parameter int          BURST_LEN  = 16,
  parameter int          FIFO_DEPTH = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          continuous,
  output logic                          busy,
  output logic                          done,
  output logic                          error,
  wshb_if.master                        wb_m,
  input  logic                          rd_en,
  output logic [31:0]                   rd_data,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int WW = $clog2(NWORDS + 1);
  localparam int BW = $clog2(BURST_LEN);
  localparam logic [LW-1:0] LMAX = LW'(FIFO_DEPTH - BURST_LEN);
  localparam logic [2:0] INCR = 3'b010;
  localparam logic [2:0] EOB  = 3'b111;

  typedef enum logic [1:0] {
    IDLE, WAIT_SPACE, BURST, GAP
  } state_t;

  state_t        state;
  logic [WW-1:0] wcnt;
  logic [WW-1:0] wnext;
  logic [BW-1:0] beat;
  logic [31:0]   adr;
  logic [2:0]    cti;
  logic          cyc;
  logic          last_beat;
  logic          space_ok;

  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          push;
  logic          pop;
  logic          full;

  assign wb_m.cyc = cyc;
  assign wb_m.stb = cyc;
  assign wb_m.we  = 1'b0;
  assign wb_m.sel = 4'hF;
  assign wb_m.bte = 2'b00;
  assign wb_m.adr = adr;
  assign wb_m.cti = cti;

  assign busy      = state != IDLE;
  assign wnext     = wcnt + 1'b1;
  assign last_beat = beat == BW'(BURST_LEN - 1);
  assign space_ok  = level <= LMAX;

  // err/rty beats carry no valid data and are never stored
  assign push = (state == BURST) && wb_m.ack
              && !wb_m.err && !wb_m.rty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cyc   <= 1'b0;
      cti   <= 3'b000;
      adr   <= BASE_ADR;
      done  <= 1'b0;
      error <= 1'b0;
      wcnt  <= '0;
      beat  <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= WAIT_SPACE;
            wcnt  <= '0;
            beat  <= '0;
            error <= 1'b0;
          end
        end
        WAIT_SPACE: begin
          // resumes mid-burst after a retry: beat is preserved
          if (space_ok) begin
            state <= BURST;
            cyc   <= 1'b1;
            adr   <= BASE_ADR + (32'(wcnt) << 2);
            cti   <= last_beat ? EOB : INCR;
          end
        end
        BURST: begin
          if (wb_m.err) begin
            error <= 1'b1;
            cyc   <= 1'b0;
            state <= IDLE;
          end else if (wb_m.rty) begin
            cyc   <= 1'b0;
            state <= GAP;
          end else if (wb_m.ack) begin
            wcnt <= wnext;
            if (last_beat) begin
              beat  <= '0;
              cyc   <= 1'b0;
              state <= GAP;
              // shows during the GAP cycle
              done  <= wnext == WW'(NWORDS);
            end else begin
              beat <= beat + 1'b1;
              adr  <= adr + 32'd4;
              cti  <= (beat == BW'(BURST_LEN - 2))
                      ? EOB : INCR;
            end
          end
        end
        GAP: begin
          if (wcnt == WW'(NWORDS)) begin
            wcnt  <= '0;
            state <= continuous ? WAIT_SPACE : IDLE;
          end else begin
            state <= WAIT_SPACE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign full    = level == LW'(FIFO_DEPTH);
  assign empty   = level == '0;
  assign pop     = rd_en && !empty;
  assign rd_data = mem[rp];

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= wb_m.dat_sm;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) assert (!(push && full));
  end
`endif

endmodule
